// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end.
package btn_pkg;

    localparam int unsigned NUM_BTN_DEF    = 5;
    localparam int unsigned DEBOUNCE_SIM   = 16;
    localparam int unsigned DEBOUNCE_BOARD = 500000;

    // Highest-index set bit of i_vec as a one-hot word; zero when nothing is set.
    function automatic logic [NUM_BTN_DEF-1:0] prio_onehot(input logic [NUM_BTN_DEF-1:0] i_vec);
        logic [NUM_BTN_DEF-1:0] r_sel;
        r_sel = '0;
        for (int i = 0; i < NUM_BTN_DEF; i++) begin
            if (i_vec[i]) begin
                r_sel    = '0;
                r_sel[i] = 1'b1;
            end
        end
        return r_sel;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-button conditioner: two-flop synchroniser, stability counter,
// debounced level and one-cycle rising-edge pulse.
module debounce_bit
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_clean,
    output logic o_press
);

    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_press;

    logic [CNT_W-1:0] w_cnt_d;
    logic             w_clean_d;

    // Count consecutive cycles where the synchronised level disagrees with the accepted one.
    always_comb begin
        w_cnt_d   = '0;
        w_clean_d = r_clean;
        if (r_sync != r_clean) begin
            if (r_cnt == CNT_MAX) begin
                w_clean_d = r_sync;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    // Synchroniser, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_raw;
            r_sync  <= r_meta;
            r_cnt   <= w_cnt_d;
            r_clean <= w_clean_d;
            r_press <= w_clean_d & ~r_clean;
        end
    end

    assign o_clean = r_clean;
    assign o_press = r_press;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end feeding led_cycle: per-button debounce plus a registered
// one-hot speed-select word. Define BTN_LATCH_EN to make speed_sel a
// press-toggled latched selection instead of following the held buttons.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] speed_sel
);

    logic [NUM_BTN-1:0] w_clean;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_sel_d;
    logic [NUM_BTN-1:0] r_sel;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[g]),
            .o_clean(w_clean[g]),
            .o_press(w_press[g])
        );
    end

`ifdef BTN_LATCH_EN
    logic [NUM_BTN-1:0] w_pick;
    assign w_pick = prio_onehot(w_press);

    // A press selects the highest pulsing button; pressing the selected one again clears it.
    always_comb begin
        w_sel_d = r_sel;
        if (|w_press) begin
            w_sel_d = (r_sel == w_pick) ? '0 : w_pick;
        end
    end
`else
    // Follow the highest held button.
    always_comb begin
        w_sel_d = prio_onehot(w_clean);
    end
`endif

    // Registered select word, one cycle behind the debounced levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else begin
            r_sel <= w_sel_d;
        end
    end

    assign btn_clean = w_clean;
    assign btn_press = w_press;
    assign speed_sel = r_sel;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (honours BTN_LATCH_EN when defined).
module tb_btn_conditioner;

    localparam int N = 5;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_clean;
    logic [N-1:0] btn_press;
    logic [N-1:0] speed_sel;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN        (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .btn_press(btn_press),
        .speed_sel(speed_sel)
    );

    // Reference model: a level is accepted once the last D synchronised samples all disagree
    // with the current accepted level.
    logic [N-1:0] m_s1, m_s2, m_clean, m_press, m_sel, m_flip;
    logic [N-1:0] m_hist [D-1];

    function automatic logic [N-1:0] hi_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i] && r == '0) r[i] = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        m_flip = '0;
        for (int b = 0; b < N; b++) begin
            logic all_diff;
            all_diff = (m_s2[b] != m_clean[b]);
            for (int j = 0; j < D - 1; j++) all_diff = all_diff && (m_hist[j][b] != m_clean[b]);
            m_flip[b] = all_diff;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_clean <= '0; m_press <= '0; m_sel <= '0;
            for (int j = 0; j < D - 1; j++) m_hist[j] <= '0;
        end else begin
            m_s1 <= btn_raw;
            m_s2 <= m_s1;
            m_hist[0] <= m_s2;
            for (int j = 1; j < D - 1; j++) m_hist[j] <= m_hist[j-1];
            m_clean <= m_clean ^ m_flip;
            m_press <= m_flip & ~m_clean;
`ifdef BTN_LATCH_EN
            if (|m_press) m_sel <= (m_sel == hi_bit(m_press)) ? '0 : hi_bit(m_press);
`else
            m_sel <= hi_bit(m_clean);
`endif
        end
    end

    task automatic apply_reset();
        rst_n   = 1'b0;
        btn_raw = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== '0) begin
                errors++;
                $display("FAIL reset_hold got %b/%b/%b want all zero", btn_clean, btn_press, speed_sel);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                errors++;
                $display("FAIL reset_model cyc %0d got %b/%b/%b want %b/%b/%b", i,
                         btn_clean, btn_press, speed_sel, m_clean, m_press, m_sel);
            end
            checks++;
            if (btn_clean !== ((i >= 18) ? 5'b11111 : 5'b00000)) begin
                errors++;
                $display("FAIL reset_release_clean cyc %0d got %b", i, btn_clean);
            end
            if (i == 19) begin
                checks++;
                if (speed_sel !== 5'b10000) begin
                    errors++;
                    $display("FAIL reset_release_sel got %b want 10000", speed_sel);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                errors++;
                $display("FAIL press_model cyc %0d got %b/%b/%b want %b/%b/%b", i,
                         btn_clean, btn_press, speed_sel, m_clean, m_press, m_sel);
            end
            checks++;
            if (btn_press[0] !== (i == 18)) begin
                errors++;
                $display("FAIL press_pulse cyc %0d got %b want %b", i, btn_press[0], (i == 18));
            end
            if (i == 19) begin
                checks++;
                if (speed_sel !== 5'b00001) begin
                    errors++;
                    $display("FAIL press_sel got %b want 00001", speed_sel);
                end
            end
        end
        btn_raw[0] = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                errors++;
                $display("FAIL release_model cyc %0d got %b/%b/%b want %b/%b/%b", i,
                         btn_clean, btn_press, speed_sel, m_clean, m_press, m_sel);
            end
            checks++;
            if (btn_press !== 5'b00000) begin
                errors++;
                $display("FAIL release_pulse cyc %0d got %b want 00000", i, btn_press);
            end
            if (i == 19) begin
                checks++;
`ifdef BTN_LATCH_EN
                if (speed_sel !== 5'b00001) begin
                    errors++;
                    $display("FAIL release_sel got %b want 00001", speed_sel);
                end
`else
                if (speed_sel !== 5'b00000) begin
                    errors++;
                    $display("FAIL release_sel got %b want 00000", speed_sel);
                end
`endif
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int t = 0; t < 200; t++) begin
            if (t % 5 == 0) btn_raw[1] = ~btn_raw[1];
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== '0 ||
                {m_clean, m_press, m_sel} !== '0) begin
                errors++;
                $display("FAIL bounce_quiet t %0d got %b/%b/%b want zero", t,
                         btn_clean, btn_press, speed_sel);
            end
        end
        btn_raw[1] = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                errors++;
                $display("FAIL bounce_model cyc %0d got %b/%b/%b want %b/%b/%b", i,
                         btn_clean, btn_press, speed_sel, m_clean, m_press, m_sel);
            end
            checks++;
            if (btn_press !== ((i == 18) ? 5'b00010 : 5'b00000)) begin
                errors++;
                $display("FAIL bounce_pulse cyc %0d got %b", i, btn_press);
            end
        end
    endtask

`ifndef BTN_LATCH_EN
    task automatic test_priority();
        apply_reset();
        btn_raw = 5'b01010;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                errors++;
                $display("FAIL prio_model cyc %0d got %b/%b/%b", i, btn_clean, btn_press, speed_sel);
            end
        end
        checks++;
        if (speed_sel !== 5'b01000) begin
            errors++;
            $display("FAIL prio_both got %b want 01000", speed_sel);
        end
        btn_raw = 5'b00010;
        for (int i = 1; i <= 22; i++) @(negedge clk);
        checks++;
        if (speed_sel !== 5'b00010 || btn_clean !== 5'b00010) begin
            errors++;
            $display("FAIL prio_low got sel %b clean %b want 00010", speed_sel, btn_clean);
        end
    endtask
`else
    task automatic test_latch();
        logic [N-1:0] pat [6];
        logic [N-1:0] want [6];
        pat  = '{5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b10001, 5'b00000};
        want = '{5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b10000, 5'b10000};
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            btn_raw = pat[s];
            for (int i = 1; i <= 22; i++) begin
                @(negedge clk);
                checks++;
                if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                    errors++;
                    $display("FAIL latch_model step %0d cyc %0d got %b/%b/%b", s, i,
                             btn_clean, btn_press, speed_sel);
                end
            end
            checks++;
            if (speed_sel !== want[s]) begin
                errors++;
                $display("FAIL latch_sel step %0d got %b want %b", s, speed_sel, want[s]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_count();
        apply_reset();
        btn_raw = 5'b00001;
        for (int i = 1; i <= 22; i++) @(negedge clk);
        checks++;
        if (btn_clean !== 5'b00001 || speed_sel !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_setup got clean %b sel %b want 00001", btn_clean, speed_sel);
        end
        btn_raw[3] = 1'b1;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_clean, btn_press, speed_sel} !== '0) begin
            errors++;
            $display("FAIL midrst_async got %b/%b/%b want zero", btn_clean, btn_press, speed_sel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (btn_clean !== ((i >= 18) ? 5'b01001 : 5'b00000)) begin
                errors++;
                $display("FAIL midrst_reaccept cyc %0d got %b", i, btn_clean);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int burst = 0; burst < 120; burst++) begin
            int dur;
            btn_raw = N'($urandom);
            dur = $urandom_range(1, 40);
            if ($urandom_range(0, 24) == 0) rst_n = 1'b0;
            for (int i = 0; i < dur; i++) begin
                if (i == 1) rst_n = 1'b1;
                if ($urandom_range(0, 9) == 0) btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
                @(negedge clk);
                checks++;
                if ({btn_clean, btn_press, speed_sel} !== {m_clean, m_press, m_sel}) begin
                    errors++;
                    $display("FAIL rand burst %0d cyc %0d got %b/%b/%b want %b/%b/%b", burst, i,
                             btn_clean, btn_press, speed_sel, m_clean, m_press, m_sel);
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
`ifndef BTN_LATCH_EN
        test_priority();
`else
        test_latch();
`endif
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
